// File: rtl/mem_arbiter_2to1.sv
// Two-master round-robin arbiter sharing one block-memory port, with a sticky
// watchdog that flags memory transactions that never complete.
module mem_arbiter_2to1 #(
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              proc_reset,
  // Port A (I-side)
  input  logic              a_read,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_ready,
  // Port B (D-side)
  input  logic              b_read,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_ready,
  // Shared memory port
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err_timeout
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StBusy, StResp, StGap} state_e;

  state_e            state_q;
  logic              last_b_q;   // 1: last completed grant went to B
  logic              grant_b_q;  // 1: current grant is B
  logic [CntW-1:0]   wd_cnt_q;

  logic              req_a, req_b, pick_b;
  logic              sel_read, sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    req_a     = a_read | a_write;
    req_b     = b_read | b_write;
    pick_b    = req_b & (~req_a | ~last_b_q);
    sel_write = pick_b ? b_write : a_write;
    sel_read  = (pick_b ? b_read : a_read) & ~sel_write;
    sel_addr  = pick_b ? b_addr : a_addr;
    sel_wdata = pick_b ? b_wdata : a_wdata;
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q     <= StIdle;
      last_b_q    <= 1'b1;
      grant_b_q   <= 1'b0;
      wd_cnt_q    <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      a_rdata     <= '0;
      b_rdata     <= '0;
      a_ready     <= 1'b0;
      b_ready     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      a_ready <= 1'b0;
      b_ready <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_a || req_b) begin
            grant_b_q <= pick_b;
            mem_read  <= sel_read;
            mem_write <= sel_write;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            wd_cnt_q  <= '0;
            state_q   <= StBusy;
          end
        end
        StBusy: begin
          if (wd_cnt_q != TimeoutCnt) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
            if ((TIMEOUT != 0) && (wd_cnt_q + 1'b1 == TimeoutCnt)) err_timeout <= 1'b1;
          end
          if (mem_ready) begin
            // rdata is captured on writes too; the master ignores it then
            if (grant_b_q) begin
              b_rdata <= mem_rdata;
              b_ready <= 1'b1;
            end else begin
              a_rdata <= mem_rdata;
              a_ready <= 1'b1;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            last_b_q  <= grant_b_q;
            state_q   <= StResp;
          end
        end
        StResp: state_q <= StGap;
        // Dead cycle so a master that registers ready cannot re-issue its stale request
        StGap:  state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Directed self-checking bench for mem_arbiter_2to1 (watchdog shortened to 8 cycles).
module tb_mem_arbiter_2to1;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         a_read, a_write, b_read, b_write;
  logic [27:0]  a_addr, b_addr;
  logic [127:0] a_wdata, b_wdata;
  logic [127:0] a_rdata, b_rdata;
  logic         a_ready, b_ready;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic         err_timeout;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  localparam logic [127:0] RdA  = 128'hDEAD0000_00000000_00000000_00000001;
  localparam logic [127:0] WdB  = 128'h12340000_00000000_00000000_00005678;
  localparam logic [127:0] WdA6 = 128'hCAFE0000_11112222_33334444_55556666;

  mem_arbiter_2to1 #(
    .ADDR_W (28),
    .DATA_W (128),
    .TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .a_read     (a_read),
    .a_write    (a_write),
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .a_rdata    (a_rdata),
    .a_ready    (a_ready),
    .b_read     (b_read),
    .b_write    (b_write),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .b_rdata    (b_rdata),
    .b_ready    (b_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  initial begin
    proc_reset = 1'b1;
    a_read = 0; a_write = 0; b_read = 0; b_write = 0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    mem_rdata = '0; mem_ready = 0;
    tick(); tick();
    chk("rst_mem_read", {127'd0, mem_read}, 128'd0);
    chk("rst_mem_write", {127'd0, mem_write}, 128'd0);
    chk("rst_mem_addr", {100'd0, mem_addr}, 128'd0);
    chk("rst_a_rdata", a_rdata, 128'd0);
    chk("rst_readies", {126'd0, a_ready, b_ready}, 128'd0);
    chk("rst_err", {127'd0, err_timeout}, 128'd0);
    proc_reset = 0;
    tick();

    // 1: A read, mem_ready at cycle 5
    a_read = 1; a_addr = 28'h0000010;
    tick();  // cycle 1
    chk("t1_c1_read", {127'd0, mem_read}, 128'd1);
    chk("t1_c1_addr", {100'd0, mem_addr}, 128'h10);
    tick(); tick(); tick();  // cycle 4
    chk("t1_c4_read", {127'd0, mem_read}, 128'd1);
    tick();  // cycle 5
    chk("t1_c5_read", {127'd0, mem_read}, 128'd1);
    chk("t1_c5_a_ready", {127'd0, a_ready}, 128'd0);
    mem_ready = 1; mem_rdata = RdA;
    tick();  // cycle 6
    mem_ready = 0; mem_rdata = '0; a_read = 0;
    chk("t1_c6_a_ready", {127'd0, a_ready}, 128'd1);
    chk("t1_c6_b_ready", {127'd0, b_ready}, 128'd0);
    chk("t1_c6_a_rdata", a_rdata, RdA);
    chk("t1_c6_read", {127'd0, mem_read}, 128'd0);
    tick();  // cycle 7
    chk("t1_c7_a_ready", {127'd0, a_ready}, 128'd0);
    chk("t1_c7_a_rdata_held", a_rdata, RdA);
    tick();

    // 2: tie from reset -> A; A re-requests while B waits -> B; then A
    proc_reset = 1; tick(); proc_reset = 0;
    a_read = 1; b_read = 1; a_addr = 28'h100; b_addr = 28'h200;
    tick();  // cycle 1
    chk("t2_first_addr", {100'd0, mem_addr}, 128'h100);
    mem_ready = 1; mem_rdata = 128'h11;
    tick();  // cycle 2 (RESP for A)
    mem_ready = 0;
    chk("t2_a_ready", {127'd0, a_ready}, 128'd1);
    chk("t2_b_ready0", {127'd0, b_ready}, 128'd0);
    a_addr = 28'h101;
    tick();  // cycle 3 GAP
    chk("t2_gap_read", {127'd0, mem_read}, 128'd0);
    tick();  // cycle 4 IDLE
    chk("t2_idle_read", {127'd0, mem_read}, 128'd0);
    tick();  // cycle 5 = k+4
    chk("t2_b_issue_read", {127'd0, mem_read}, 128'd1);
    chk("t2_b_issue_addr", {100'd0, mem_addr}, 128'h200);
    mem_ready = 1; mem_rdata = 128'h22;
    tick();
    mem_ready = 0; b_read = 0;
    chk("t2_b_ready", {127'd0, b_ready}, 128'd1);
    chk("t2_b_rdata", b_rdata, 128'h22);
    chk("t2_a_rdata_held", a_rdata, 128'h11);
    tick(); tick(); tick();
    chk("t2_a_again_addr", {100'd0, mem_addr}, 128'h101);
    chk("t2_a_again_read", {127'd0, mem_read}, 128'd1);
    mem_ready = 1; mem_rdata = 128'h33;
    tick();
    mem_ready = 0; a_read = 0;
    chk("t2_a_ready2", {127'd0, a_ready}, 128'd1);
    tick(); tick();

    // 3: B write, A request arrives mid-BUSY
    b_write = 1; b_addr = 28'h0ABCDEF; b_wdata = WdB;
    tick();  // cycle 1
    chk("t3_write", {127'd0, mem_write}, 128'd1);
    chk("t3_read0", {127'd0, mem_read}, 128'd0);
    a_read = 1; a_addr = 28'h55;
    tick(); tick();  // cycle 3
    chk("t3_addr_stable", {100'd0, mem_addr}, 128'h0ABCDEF);
    chk("t3_wdata_stable", mem_wdata, WdB);
    chk("t3_read_still0", {127'd0, mem_read}, 128'd0);
    mem_ready = 1; mem_rdata = 128'hAA;
    tick();  // RESP
    mem_ready = 0; b_write = 0;
    chk("t3_b_ready", {127'd0, b_ready}, 128'd1);
    chk("t3_a_ready0", {127'd0, a_ready}, 128'd0);
    chk("t3_b_rdata", b_rdata, 128'hAA);
    tick();  // GAP
    chk("t3_gap_read", {127'd0, mem_read}, 128'd0);
    tick();  // IDLE
    chk("t3_idle_read", {127'd0, mem_read}, 128'd0);
    tick();
    chk("t3_a_granted", {127'd0, mem_read}, 128'd1);
    chk("t3_a_addr", {100'd0, mem_addr}, 128'h55);
    mem_ready = 1; mem_rdata = 128'hBB;
    tick();
    mem_ready = 0;
    chk("t3_a_rdata", a_rdata, 128'hBB);
    chk("t3_b_rdata_held", b_rdata, 128'hAA);

    // 4: A (still requesting) holds a_read one cycle past its ready
    tick();  // GAP, a_read still high
    a_read = 0;
    tick(); tick(); tick();
    chk("t4_no_dup_read", {127'd0, mem_read}, 128'd0);
    a_read = 1; a_addr = 28'h66;
    tick();
    mem_ready = 1; mem_rdata = 128'hCC;
    tick();  // RESP: a_ready=1, master still requests
    mem_ready = 0;
    chk("t4_a_ready", {127'd0, a_ready}, 128'd1);
    tick();  // GAP: master has seen ready, drops request
    a_read = 0;
    chk("t4_gap_read", {127'd0, mem_read}, 128'd0);
    tick();
    chk("t4_idle_read", {127'd0, mem_read}, 128'd0);
    tick();
    chk("t4_no_reissue", {127'd0, mem_read}, 128'd0);

    // 6: read+write on A -> write wins
    a_read = 1; a_write = 1; a_addr = 28'h77; a_wdata = WdA6;
    tick();
    chk("t6_write", {127'd0, mem_write}, 128'd1);
    chk("t6_read0", {127'd0, mem_read}, 128'd0);
    chk("t6_wdata", mem_wdata, WdA6);
    mem_ready = 1; mem_rdata = 128'h0;
    tick();
    mem_ready = 0; a_read = 0; a_write = 0;
    tick(); tick();

    // 5: watchdog with TIMEOUT=8, then reset mid-BUSY
    b_read = 1; b_addr = 28'h99;
    tick();  // BUSY cycle 1
    for (int i = 0; i < 7; i++) tick();  // cycle 8
    chk("t5_err_c8", {127'd0, err_timeout}, 128'd0);
    tick();  // cycle 9
    chk("t5_err_c9", {127'd0, err_timeout}, 128'd1);
    chk("t5_read_held", {127'd0, mem_read}, 128'd1);
    chk("t5_addr_held", {100'd0, mem_addr}, 128'h99);
    tick(); tick();
    chk("t5_err_sticky", {127'd0, err_timeout}, 128'd1);
    chk("t5_no_ready", {126'd0, a_ready, b_ready}, 128'd0);
    proc_reset = 1;
    tick();
    proc_reset = 0; b_read = 0;
    chk("t5_rst_err", {127'd0, err_timeout}, 128'd0);
    chk("t5_rst_read", {127'd0, mem_read}, 128'd0);
    chk("t5_rst_addr", {100'd0, mem_addr}, 128'd0);
    chk("t5_rst_rdata", b_rdata, 128'd0);
    a_read = 1; a_addr = 28'h44;
    tick();
    chk("t5_idle_after_rst", {127'd0, mem_read}, 128'd1);
    a_read = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
